// File: rtl/data_memory_responder.sv
// Responder for the core's load/store data-memory port: one outstanding RV32I access,
// byte-lane RAM, response after a fixed latency with size/alignment/range checking.
module data_memory_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg, err_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  lane_reg;

  logic        accept;
  logic [32:0] diff;
  logic        in_range, size_ok, misaligned, req_err;
  logic [AW-1:0] word_idx;
  logic [1:0]  lane;
  logic [3:0]  lane_we;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign accept = req_valid && req_ready;

  // 33-bit subtraction: the borrow bit flags addresses below BASE_ADDR without overflow.
  assign diff     = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_range = !diff[32] && (diff[31:AW+2] == '0);
  assign word_idx = diff[AW+1:2];
  assign lane     = diff[1:0];

  assign size_ok    = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                             : ((req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110));
  assign misaligned = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
  assign req_err    = !size_ok || misaligned || !in_range;

  always_comb begin
    lane_we = '0;
    if (accept && req_we && !req_err) begin
      case (req_funct3[1:0])
        2'b00:   lane_we[lane] = 1'b1;
        2'b01:   lane_we = lane[1] ? 4'b1100 : 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
  end

  // One byte-wide RAM per lane; read is captured at the acceptance edge and held for the response.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte;
      logic [7:0] wr_byte;

      assign wr_byte = (req_funct3[1:0] == 2'b10) ? req_wdata[8*gi +: 8] :
                       (req_funct3[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                    req_wdata[7:0];

      always_ff @(posedge clk) begin
        if (lane_we[gi]) mem[word_idx] <= wr_byte;
        if (accept) rd_byte <= mem[word_idx];
      end

      assign rd_word[8*gi +: 8] = rd_byte;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      we_reg     <= 1'b0;
      err_reg    <= 1'b0;
      funct3_reg <= '0;
      lane_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg     <= req_we;
        err_reg    <= req_err;
        funct3_reg <= req_funct3;
        lane_reg   <= lane;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) state_next = S_RESP;
        else cnt_next = cnt_reg - 4'd1;
      end
      S_RESP: if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign byte_sel = rd_word[{lane_reg, 3'b000} +: 8];
  assign half_sel = lane_reg[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    req_ready  = (state_reg == S_IDLE) && !reset;
    resp_valid = (state_reg == S_RESP);
    resp_err   = resp_valid && err_reg;
    resp_rdata = '0;
    if (resp_valid && !we_reg && !err_reg) begin
      case (funct3_reg)
        3'b000:  resp_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  resp_rdata = {24'b0, byte_sel};
        3'b001:  resp_rdata = {{16{half_sel[15]}}, half_sel};
        3'b101:  resp_rdata = {16'b0, half_sel};
        default: resp_rdata = rd_word;
      endcase
    end
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's load/store data-memory interface: accepts one load or store request at a time over a valid/ready channel and returns a response after a configurable latency.
- Handles RV32I access sizes (byte, half, word) and sign/zero extension, and flags misaligned, out-of-range and unsupported-size accesses.
- Sits between the core's MEM stage and on-chip word-organised RAM; one outstanding transaction at a time.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of 2, >= 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; multiple of 4*DEPTH.
- LATENCY, 2, cycles from request acceptance to response valid; integer, 1 to 15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts response.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  access fault.

Behaviour:
- Reset values (while reset is high and immediately after): state IDLE, req_ready=0 while reset is high, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Reset does not clear memory contents: contents are undefined at power-up and preserved across reset.
- FSM states:
  - IDLE: req_ready=1 when reset is low.
  - WAIT: counting latency.
  - RESP: resp_valid=1.
- Acceptance: a request is accepted at a rising edge with req_valid && req_ready.
  - All request fields are sampled at that edge.
  - Error check, read data capture and store commit all happen at that same edge.
- Transitions:
  - IDLE -> RESP on accept if LATENCY=1; otherwise IDLE -> WAIT with the counter loaded so that resp_valid first rises exactly LATENCY cycles after the accept cycle.
  - WAIT -> RESP when the counter expires.
  - RESP -> IDLE at the edge where resp_ready=1.
- Backpressure: resp_valid, resp_rdata and resp_err stay stable while resp_ready=0.
- Throughput: req_ready=0 in WAIT and RESP, so a new request can be accepted no earlier than the cycle after the response handshake. Maximum throughput is one transaction per LATENCY+1 cycles.
- Errors (resp_err=1, no memory write, resp_rdata=0):
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH, computed without 32-bit overflow.
  - Unsupported funct3: load 011/110/111, store 011 to 111.
- Addressing: word index = (addr - BASE_ADDR)[log2(DEPTH)+1:2]; byte lane = addr[1:0]; half lane = addr[1].
- Stores: write only the addressed lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes); other lanes are unchanged. Response has rdata=0 and err=0.
- Loads: select the lane and shift it to bit 0.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns the word unmodified.
- Ordering: a load issued after a store's response handshake sees the stored data.
- Reset mid-operation (in WAIT or RESP): the pending response is discarded, with no resp_valid after reset. A store already committed at its acceptance edge stays committed.
- req_valid may drop without acceptance; no request-side state is kept in that case.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (LATENCY=2) -> store response err=0 rdata=0; load resp_valid rises 2 cycles after accept with rdata=0xDEADBEEF.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata=0x12345677, then LW 0x10 -> 0xDEAD77EF; SH 0x12 wdata=0x0000CAFE, then LW 0x10 -> 0xCAFE77EF.
- LW 0x12, SH 0x01, LW 4*DEPTH, load funct3=011 -> all err=1, rdata=0; a following LW 0x10 returns the unchanged 0xCAFE77EF.
- Hold resp_ready=0 for 5 cycles during a response -> resp_valid/rdata/err stable and req_ready=0 throughout; the next request is accepted only the cycle after the handshake.
- Assert reset during WAIT of an SW 0x20 wdata=0x11111111, then LW 0x20 -> no stale response after reset; load returns 0x11111111. Repeat with LATENCY=1: resp_valid is high the cycle after accept.
